// File: rtl/alu_sequencer.sv
// alu_sequencer: command sequencer around an external combinational 8-bit ALU
// Ports: clk/rst_n (async active-low); cmd_* command handshake and fields;
//        alu_a/alu_b/alu_op drive the ALU, alu_y/alu_c/v/n/z return its result;
//        rsp_* response handshake with data and {C,V,N,Z} flags; busy when not idle.
module alu_sequencer #(
  parameter logic [2:0] ADD_OP = 3'b000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_mode,
  input  logic [2:0] cmd_op,
  input  logic [1:0] cmd_dst,
  input  logic [1:0] cmd_srca,
  input  logic [1:0] cmd_srcb,
  input  logic [7:0] cmd_imm,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_y,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic       alu_n,
  input  logic       alu_z,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [3:0] rsp_flags,
  output logic       busy
);
  localparam logic [1:0] M_ALU = 2'b00, M_LOAD = 2'b01, M_MUL = 2'b10;
  typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;
  state_t state, state_nx;
  logic [7:0] regs [4];
  logic [3:0] flags;
  logic [1:0] mode, dst;
  logic [2:0] op, step;
  logic [7:0] opa, opb, imm, acc, acc_nx;
  logic       csticky, cst_nx, take;
  logic [3:0] mul_flags;
  // opa/opb are captured at accept, so sources always see pre-write values
  assign take      = opb[step];
  assign acc_nx    = take ? alu_y : acc;
  assign cst_nx    = csticky | (take & alu_c);
  assign mul_flags = {cst_nx, 1'b0, acc_nx[7], acc_nx == 8'd0};
  assign cmd_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign busy      = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    alu_a    = 8'd0;
    alu_b    = 8'd0;
    alu_op   = 3'b000;
    case (state)
      IDLE: if (cmd_valid) state_nx = cmd_mode == M_MUL ? MUL : EXEC;
      EXEC: begin
        state_nx = RESP;
        if (mode == M_ALU) begin
          alu_a  = opa;
          alu_b  = opb;
          alu_op = op;
        end
      end
      MUL: begin
        alu_a    = acc;
        alu_b    = opa << step;
        alu_op   = ADD_OP;
        state_nx = step == 3'd7 ? RESP : MUL;
      end
      default: if (rsp_ready) state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      regs      <= '{default: 8'd0};
      flags     <= 4'd0;
      mode      <= 2'd0;
      dst       <= 2'd0;
      op        <= 3'd0;
      step      <= 3'd0;
      opa       <= 8'd0;
      opb       <= 8'd0;
      imm       <= 8'd0;
      acc       <= 8'd0;
      csticky   <= 1'b0;
      rsp_data  <= 8'd0;
      rsp_flags <= 4'd0;
    end else
      case (state)
        IDLE: if (cmd_valid) begin
          mode    <= cmd_mode;
          op      <= cmd_op;
          dst     <= cmd_dst;
          imm     <= cmd_imm;
          opa     <= regs[cmd_srca];
          opb     <= regs[cmd_srcb];
          acc     <= 8'd0;
          csticky <= 1'b0;
          step    <= 3'd0;
        end
        EXEC: begin
          rsp_data  <= mode == M_ALU ? alu_y : mode == M_LOAD ? imm : opa;
          rsp_flags <= mode == M_ALU ? {alu_c, alu_v, alu_n, alu_z} : flags;
          if (mode == M_ALU) begin
            regs[dst] <= alu_y;
            flags     <= {alu_c, alu_v, alu_n, alu_z};
          end
          if (mode == M_LOAD) regs[dst] <= imm;
        end
        MUL: begin
          acc     <= acc_nx;
          csticky <= cst_nx;
          step    <= step + 3'd1;
          if (step == 3'd7) begin
            regs[dst] <= acc_nx;
            flags     <= mul_flags;
            rsp_data  <= acc_nx;
            rsp_flags <= mul_flags;
          end
        end
        default: ;
      endcase
endmodule
